// File: rtl/chk_sched_pkg.sv
// Shared types and defaults for the checker scheduler.
package chk_sched_pkg;
  localparam int NREQ_DEF    = 8;
  localparam int WIDTH_DEF   = 32;
  localparam int ERR_MAX_DEF = 16;
  localparam int ERR_W       = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Index width for n requesters; never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chk_sched_rr_arb.sv
// Round-robin arbiter: searches from i_ptr+1 upward with wrap, skipping masked requesters.
module rr_arb import chk_sched_pkg::*; #(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt
);
  logic [NREQ-1:0] w_elig;
  logic [IW-1:0]   w_idx;
  logic            w_found;

  assign w_elig = i_req & ~i_mask;

  // First eligible requester after the pointer wins; offset NREQ revisits the pointer itself last.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && w_elig[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/chk_sched.sv
// Checker scheduler: arbitrates NREQ requesters onto one comparator, counts mismatches per run.
module chk_sched import chk_sched_pkg::*; #(
  parameter  int NREQ    = NREQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int ERR_MAX = ERR_MAX_DEF,
  localparam int IW      = idx_w(NREQ)
) (
  input  logic                  chk_sched_clk_ip,
  input  logic                  chk_sched_rst_ip,
  input  logic                  chk_sched_start_ip,
  input  logic [31:0]           chk_sched_timeout_ip,
  input  logic [NREQ-1:0]       chk_sched_req_ip,
  input  logic [NREQ*WIDTH-1:0] chk_sched_sig0_ip,
  input  logic [NREQ*WIDTH-1:0] chk_sched_sig1_ip,
  output logic [NREQ-1:0]       chk_sched_gnt_op,
  output logic [ERR_W-1:0]      chk_sched_err_cnt_op,
  output logic                  chk_sched_first_err_vld_op,
  output logic [IW-1:0]         chk_sched_first_err_idx_op,
  output logic                  chk_sched_busy_op,
  output logic                  chk_sched_finish_op
);
  state_t           r_state, w_nxt;
  logic [31:0]      r_cnt, r_tmo, w_tmo_eff;
  logic [NREQ-1:0]  r_gnt, w_win, w_req;
  logic [IW-1:0]    r_ptr, w_win_idx, r_cmp_idx, r_first_idx;
  logic [WIDTH-1:0] w_a, w_b, r_a, r_b;
  logic             r_cmp_vld, r_first_vld;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic             w_win_any, w_mis, w_err_stop, w_tmo_hit, w_run, w_enter;

  assign w_run     = (r_state == S_RUN);
  assign w_req     = chk_sched_req_ip & {NREQ{w_run}};
  assign w_win_any = |w_win;

  // A requester holding the grant this cycle is masked so it cannot win twice in a row.
  rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req  (w_req),
    .i_mask (r_gnt),
    .i_ptr  (r_ptr),
    .o_gnt  (w_win)
  );

  // Winner index and operand slices selected from the one-hot winner.
  always_comb begin
    w_win_idx = '0;
    w_a       = '0;
    w_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_idx = IW'(i);
        w_a       = chk_sched_sig0_ip[i*WIDTH +: WIDTH];
        w_b       = chk_sched_sig1_ip[i*WIDTH +: WIDTH];
      end
    end
  end

  // Compare of the pair captured last cycle, saturating count, and run-end conditions.
  always_comb begin
    w_mis      = r_cmp_vld && (r_a != r_b);
    w_err_nxt  = (w_mis && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;
    w_err_stop = w_mis && (w_err_nxt >= ERR_W'(ERR_MAX));
    w_tmo_eff  = (r_tmo == 32'd0) ? 32'd1 : r_tmo;
    w_tmo_hit  = (r_cnt == w_tmo_eff - 32'd1);
  end

  // State register.
  always_ff @(posedge chk_sched_clk_ip) begin
    if (chk_sched_rst_ip) r_state <= S_IDLE;
    else                  r_state <= w_nxt;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (chk_sched_start_ip) w_nxt = S_RUN;
      S_RUN:   if (w_tmo_hit || w_err_stop) w_nxt = S_DRAIN;
      S_DRAIN: w_nxt = S_DONE;
      S_DONE:  if (chk_sched_start_ip) w_nxt = S_RUN;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; finish holds for as long as DONE does.
  always_comb begin
    chk_sched_busy_op   = (r_state == S_RUN) || (r_state == S_DRAIN);
    chk_sched_finish_op = (r_state == S_DONE);
  end

  assign w_enter = (w_nxt == S_RUN) && !w_run;

  // Capture, grant, counters. A winner picked on the last RUN cycle is still captured and
  // compared during DRAIN, but its grant is suppressed so gnt stays zero outside RUN.
  always_ff @(posedge chk_sched_clk_ip) begin
    if (chk_sched_rst_ip) begin
      r_gnt       <= '0;
      r_ptr       <= IW'(NREQ-1);
      r_a         <= '0;
      r_b         <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_idx   <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_err       <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else begin
      r_gnt     <= (w_run && (w_nxt == S_RUN)) ? w_win : '0;
      r_cmp_vld <= w_win_any;
      if (w_win_any) begin
        r_a       <= w_a;
        r_b       <= w_b;
        r_cmp_idx <= w_win_idx;
        r_ptr     <= w_win_idx;
      end
      if (w_enter) begin
        r_cnt       <= '0;
        r_tmo       <= chk_sched_timeout_ip;
        r_err       <= '0;
        r_first_vld <= 1'b0;
      end else begin
        if (w_run) r_cnt <= r_cnt + 32'd1;
        r_err <= w_err_nxt;
        if (w_mis && !r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= r_cmp_idx;
        end
      end
    end
  end

  assign chk_sched_gnt_op           = r_gnt;
  assign chk_sched_err_cnt_op       = r_err;
  assign chk_sched_first_err_vld_op = r_first_vld;
  assign chk_sched_first_err_idx_op = r_first_idx;
endmodule

// File: tb/tb_chk_sched.sv
// Scoreboard bench for chk_sched: grants and end-of-run results are queued when each
// run is launched and popped by a monitor when the DUT shows a grant or raises finish.
module tb_chk_sched;
  localparam int NREQ = 8;
  localparam int W    = 32;

  typedef struct {
    logic [15:0] err;
    logic        vld;
    logic [2:0]  idx;
  } fin_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [31:0]         tmo = '0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*W-1:0]   sig0 = '0, sig1 = '0;
  logic [NREQ-1:0]     gnt;
  logic [15:0]         err_cnt;
  logic                fvld, busy, finish;
  logic [2:0]          fidx;

  int   exp_gnt[$];
  fin_t exp_fin[$];
  int   d_chk = 0, d_pass = 0, m_chk = 0, m_pass = 0;
  logic [NREQ-1:0] prev_gnt = '0;
  logic            prev_fin = 1'b0;

  chk_sched dut (
    .chk_sched_clk_ip           (clk),
    .chk_sched_rst_ip           (rst),
    .chk_sched_start_ip         (start),
    .chk_sched_timeout_ip       (tmo),
    .chk_sched_req_ip           (req),
    .chk_sched_sig0_ip          (sig0),
    .chk_sched_sig1_ip          (sig1),
    .chk_sched_gnt_op           (gnt),
    .chk_sched_err_cnt_op       (err_cnt),
    .chk_sched_first_err_vld_op (fvld),
    .chk_sched_first_err_idx_op (fidx),
    .chk_sched_busy_op          (busy),
    .chk_sched_finish_op        (finish)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    d_chk++;
    if (act === exp) d_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic start_run(input logic [31:0] t);
    tmo = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Slice i gets a distinct pattern; mis_mask selects requesters whose operands differ.
  task automatic set_sig(input logic [NREQ-1:0] mis_mask);
    for (int i = 0; i < NREQ; i++) begin
      sig0[i*W +: W] = 32'hA5A5_0000 + i;
      sig1[i*W +: W] = mis_mask[i] ? (32'hA5A5_0000 + i) ^ 32'h0000_0100 : 32'hA5A5_0000 + i;
    end
  endtask

  task automatic push_fin(input logic [15:0] e, input logic v, input logic [2:0] ix);
    fin_t f;
    f.err = e; f.vld = v; f.idx = ix;
    exp_fin.push_back(f);
  endtask

  // Monitor: every visible grant and every rising finish is matched against the queues.
  always @(negedge clk) begin
    int   e;
    fin_t f;
    if (gnt != '0) begin
      m_chk++;
      if (exp_gnt.size() == 0) $display("FAIL gnt_unexpected: got %b want none", gnt);
      else begin
        e = exp_gnt.pop_front();
        if (gnt == NREQ'(1 << e)) m_pass++;
        else $display("FAIL gnt_order: got %b want idx %0d", gnt, e);
      end
      m_chk++;
      if (gnt != prev_gnt) m_pass++;
      else $display("FAIL gnt_double: got %b twice want change", gnt);
    end
    if (finish && !prev_fin) begin
      m_chk++;
      if (exp_fin.size() == 0) $display("FAIL fin_unexpected: got finish want none");
      else begin
        f = exp_fin.pop_front();
        if (err_cnt == f.err && fvld == f.vld && (!f.vld || fidx == f.idx)) m_pass++;
        else $display("FAIL fin_result: got err=%0d vld=%0b idx=%0d want err=%0d vld=%0b idx=%0d",
                      err_cnt, fvld, fidx, f.err, f.vld, f.idx);
      end
    end
    prev_gnt = gnt;
    prev_fin = finish;
  end

  initial begin
    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_fvld", 32'(fvld), 0);
    chk("rst_fidx", 32'(fidx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fin", 32'(finish), 0);

    // Timeout-only run, no requesters: DRAIN after edge 20, finish after edge 21
    push_fin(16'd0, 1'b0, 3'd0);
    start_run(32'd20);
    chk("t1_busy0", 32'(busy), 1);
    repeat (20) tick();
    chk("t1_drain_busy", 32'(busy), 1);
    chk("t1_drain_fin", 32'(finish), 0);
    tick();
    chk("t1_fin", 32'(finish), 1);
    chk("t1_busy_done", 32'(busy), 0);

    // Only requester 3, mismatching: count steps every other cycle, 5 grants in 10 cycles
    req = 8'b0000_1000;
    set_sig('0);
    sig0[3*W +: W] = 32'h5;
    sig1[3*W +: W] = 32'h4;
    repeat (5) exp_gnt.push_back(3);
    push_fin(16'd5, 1'b1, 3'd3);
    start_run(32'd10);
    tick(); chk("t3_err_e1", 32'(err_cnt), 0); chk("t3_vld_e1", 32'(fvld), 0);
    tick(); chk("t3_err_e2", 32'(err_cnt), 1); chk("t3_vld_e2", 32'(fvld), 1);
    chk("t3_idx_e2", 32'(fidx), 3);
    tick(); chk("t3_err_e3", 32'(err_cnt), 1);
    tick(); chk("t3_err_e4", 32'(err_cnt), 2);
    repeat (7) tick();
    chk("t3_fin", 32'(finish), 1);

    // All requesters mismatching: 16th error forces DRAIN, in-flight pair makes 17
    req = '1;
    set_sig('1);
    for (int c = 0; c < 16; c++) exp_gnt.push_back((4 + c) % 8);
    push_fin(16'd17, 1'b1, 3'd4);
    start_run(32'd100);
    repeat (17) tick();
    chk("t4_err16", 32'(err_cnt), 16);
    chk("t4_drain_busy", 32'(busy), 1);
    chk("t4_drain_fin", 32'(finish), 0);
    tick();
    chk("t4_fin", 32'(finish), 1);
    chk("t4_err17", 32'(err_cnt), 17);
    chk("t4_fidx", 32'(fidx), 4);

    // Restart from DONE with matching data: finish and counters clear on entry
    set_sig('0);
    for (int c = 0; c < 11; c++) exp_gnt.push_back((5 + c) % 8);
    push_fin(16'd0, 1'b0, 3'd0);
    start_run(32'd12);
    chk("t2_fin_clr", 32'(finish), 0);
    chk("t2_err_clr", 32'(err_cnt), 0);
    chk("t2_fvld_clr", 32'(fvld), 0);
    repeat (13) tick();
    chk("t2_fin", 32'(finish), 1);

    // Reset mid-RUN with a mismatching compare in flight, then reset against start
    set_sig('1);
    exp_gnt.push_back(1);
    start_run(32'd100);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_err", 32'(err_cnt), 0);
    chk("t5_fvld", 32'(fvld), 0);
    chk("t5_fidx", 32'(fidx), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_fin", 32'(finish), 0);
    start = 1'b1;
    tick();
    chk("t5_rst_dom", 32'(busy), 0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_err", 32'(err_cnt), 0);

    // Fresh pointer after reset: order 0..7,0 with matching data
    set_sig('0);
    for (int c = 0; c < 9; c++) exp_gnt.push_back(c % 8);
    push_fin(16'd0, 1'b0, 3'd0);
    start_run(32'd10);
    repeat (11) tick();
    chk("t6_fin", 32'(finish), 1);
    chk("t6_err", 32'(err_cnt), 0);

    repeat (3) tick();
    chk("gnt_queue_empty", 32'(exp_gnt.size()), 0);
    chk("fin_queue_empty", 32'(exp_fin.size()), 0);
    $display("%0d/%0d checks passed", d_pass + m_pass, d_chk + m_chk);
    $finish;
  end
endmodule
